uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Sequencing and buffering controller for the UART receiver. It owns the receiver's configuration (Prescale, Parity_En, Parity_Typ) and changes it only between frames. It monitors the serial line and the receiver's status pulses to track frame activity. Received words are buffered in a small FIFO with a valid/ready output, and parity/framing error statistics are kept.

## Interface
- WIDTH, 8, data word width; must match the receiver's width
- DEPTH, 4, FIFO depth in words; power of two, ≥2
- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  synchronous, active-low reset
- Cfg_Wr  in  1  one-cycle configuration write strobe
- Cfg_Prescale  in  6  requested oversampling ratio
- Cfg_Par_En  in  1  requested parity enable
- Cfg_Par_Typ  in  1  requested parity type (0 even, 1 odd)
- Cfg_Busy  out  1  pending configuration not yet applied
- Rx_in  in  1  serial line, same net driving the receiver
- Prescale  out  6  applied oversampling ratio, to receiver
- Parity_En  out  1  applied parity enable, to receiver
- Parity_Typ  out  1  applied parity type, to receiver
- P_Data  in  WIDTH  receiver parallel data
- Data_Valid  in  1  receiver word-valid pulse
- Parity_Err  in  1  receiver parity error
- Framing_Err  in  1  receiver framing error
- Out_Data  out  WIDTH  FIFO head word
- Out_Valid  out  1  FIFO non-empty
- Out_Ready  in  1  consumer accepts head word
- Overrun  out  1  sticky: word dropped on full FIFO
- Par_Err_Cnt  out  8  saturating parity-error count
- Frm_Err_Cnt  out  8  saturating framing-error count
- Clr_Stat  in  1  clears Overrun and both counters

## Operation
- FSM states: IDLE, APPLY, BUSY, WAIT_HIGH.
- Cfg_Wr in any state loads the pending register and sets Cfg_Busy. A second write before apply overwrites the pending value.
- IDLE: pending set -> APPLY (priority). Otherwise Rx_in==0 -> BUSY, loading timeout counter T = (WIDTH+3)*Prescale. Product width is ceil(log2((WIDTH+3)*63+1)) bits, 10 bits at WIDTH=8.
- APPLY: pending copied to Prescale/Parity_En/Parity_Typ; Cfg_Busy clears. Next state is BUSY if Rx_in==0 (T loaded with the new Prescale), else IDLE.
- BUSY: T decrements each cycle.
  - Data_Valid, Parity_Err or Framing_Err -> WAIT_HIGH.
  - T==0 -> WAIT_HIGH.
  - Cfg_Wr is held pending; Prescale etc. never change in BUSY or WAIT_HIGH.
- WAIT_HIGH: Rx_in==1 -> IDLE. This stops a low stop bit from being taken as a new start.
- FIFO push on Data_Valid in any state, data = P_Data.
  - Pop when Out_Valid && Out_Ready.
  - Push on full without pop: word dropped, Overrun set.
  - Push and pop together on full: both succeed, no Overrun.
  - Pointers wrap modulo DEPTH; an occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- Counters: +1 per cycle with the corresponding error high; saturate at 255. Clr_Stat has priority over a same-cycle increment and over a same-cycle overrun.

## Timing
- Reset (Rst==0 at edge), outputs:
  - Prescale=8, Parity_En=0, Parity_Typ=0
  - Cfg_Busy=0, Out_Valid=0, Out_Data=0 (storage cleared)
  - Overrun=0, both counts 0
  - state IDLE, pending cleared
- Reset mid-frame discards FIFO contents and pending configuration.
- Cfg_Wr at edge N in IDLE: Cfg_Busy=1 after N, APPLY during N+1, new config and Cfg_Busy=0 after edge N+1.
- Data_Valid at edge N into empty FIFO: Out_Valid=1 and Out_Data valid after N. Pop at edge M: next word or Out_Valid=0 after M.
- Error pulse at edge N: count updated after N.
- All outputs registered except Out_Data/Out_Valid, which are decoded from registered storage/occupancy.

## Configuration
- UART_RX_ERR_STAT_EN defined: Par_Err_Cnt/Frm_Err_Cnt implemented as above.
- Undefined: both counters are tied to 0, with no counter registers. Overrun and Clr_Stat still function.

## Test plan
- Reset, then idle: Prescale=8, Parity_En=0, Out_Valid=0, counts 0.
- Start frame (Rx_in low, FSM in BUSY) and Cfg_Wr Prescale=16 mid-frame: Prescale stays 8 until Data_Valid plus Rx_in high, then becomes 16 two cycles later; Cfg_Busy 1 throughout the wait.
- Push 0x11,0x22,0x33,0x44,0x55 with Out_Ready=0 (DEPTH=4): Out_Data=0x11, Overrun=1, 0x55 lost. Then drain gives 0x11..0x44 in order and Out_Valid=0.
- Full FIFO with Data_Valid and Out_Ready in the same cycle: no Overrun, occupancy stays 4, new word at tail.
- 300 Parity_Err pulses: Par_Err_Cnt=255. Clr_Stat together with Framing_Err: Frm_Err_Cnt=0.
- Rx_in held low indefinitely, no receiver pulses: BUSY exits after 11*Prescale cycles to WAIT_HIGH and holds until Rx_in=1.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: frame-aware configuration apply, output FIFO, error statistics.
// Optional feature macro: UART_RX_ERR_STAT_EN (parity/framing error counters).
module uart_rx_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Cfg_Wr,
  input  logic [5:0]       Cfg_Prescale,
  input  logic             Cfg_Par_En,
  input  logic             Cfg_Par_Typ,
  output logic             Cfg_Busy,
  input  logic             Rx_in,
  output logic [5:0]       Prescale,
  output logic             Parity_En,
  output logic             Parity_Typ,
  input  logic [WIDTH-1:0] P_Data,
  input  logic             Data_Valid,
  input  logic             Parity_Err,
  input  logic             Framing_Err,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Overrun,
  output logic [7:0]       Par_Err_Cnt,
  output logic [7:0]       Frm_Err_Cnt,
  input  logic             Clr_Stat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2((WIDTH + 3) * 63 + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] APPLY     = 2'd1;
  localparam logic [1:0] BUSY      = 2'd2;
  localparam logic [1:0] WAIT_HIGH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [5:0]    presc_q, presc_d;
  logic          par_en_q, par_en_d;
  logic          par_typ_q, par_typ_d;
  logic [5:0]    pend_presc_q, pend_presc_d;
  logic          pend_par_en_q, pend_par_en_d;
  logic          pend_par_typ_q, pend_par_typ_d;
  logic          pend_valid_q, pend_valid_d;

  // Frame timeout: start + data + parity + stop bits, in oversample ticks.
  function automatic logic [TW-1:0] frame_ticks(input logic [5:0] p);
    return TW'(WIDTH + 3) * TW'(p);
  endfunction

  always_comb begin
    state_d        = state_q;
    tmr_d          = tmr_q;
    presc_d        = presc_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    pend_presc_d   = pend_presc_q;
    pend_par_en_d  = pend_par_en_q;
    pend_par_typ_d = pend_par_typ_q;
    pend_valid_d   = pend_valid_q;

    if (Cfg_Wr) begin
      pend_presc_d   = Cfg_Prescale;
      pend_par_en_d  = Cfg_Par_En;
      pend_par_typ_d = Cfg_Par_Typ;
      pend_valid_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q || Cfg_Wr) begin
          state_d = APPLY;
        end else if (!Rx_in) begin
          state_d = BUSY;
          tmr_d   = frame_ticks(presc_q);
        end
      end
      APPLY: begin
        presc_d   = pend_presc_q;
        par_en_d  = pend_par_en_q;
        par_typ_d = pend_par_typ_q;
        // A write landing on the apply edge stays pending for the next round.
        if (!Cfg_Wr) pend_valid_d = 1'b0;
        if (!Rx_in) begin
          state_d = BUSY;
          tmr_d   = frame_ticks(pend_presc_q);
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (tmr_q != '0) tmr_d = tmr_q - TW'(1);
        if (Data_Valid || Parity_Err || Framing_Err || (tmr_q == '0)) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (Rx_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q        <= IDLE;
      tmr_q          <= '0;
      presc_q        <= 6'd8;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      pend_presc_q   <= '0;
      pend_par_en_q  <= 1'b0;
      pend_par_typ_q <= 1'b0;
      pend_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      presc_q        <= presc_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      pend_presc_q   <= pend_presc_d;
      pend_par_en_q  <= pend_par_en_d;
      pend_par_typ_q <= pend_par_typ_d;
      pend_valid_q   <= pend_valid_d;
    end
  end

  assign Prescale   = presc_q;
  assign Parity_En  = par_en_q;
  assign Parity_Typ = par_typ_q;
  assign Cfg_Busy   = pend_valid_q;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             full, pop, push_ok;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    pop       = (count_q != '0) && Out_Ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push_ok   = Data_Valid && (!full || pop);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = P_Data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop) count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    if (Clr_Stat) overrun_d = 1'b0;
    else if (Data_Valid && !push_ok) overrun_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign Out_Data  = mem_q[rd_ptr_q];
  assign Out_Valid = (count_q != '0);
  assign Overrun   = overrun_q;

`ifdef UART_RX_ERR_STAT_EN
  logic [7:0] par_cnt_q, par_cnt_d;
  logic [7:0] frm_cnt_q, frm_cnt_d;

  always_comb begin
    par_cnt_d = par_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (Clr_Stat) begin
      par_cnt_d = '0;
      frm_cnt_d = '0;
    end else begin
      if (Parity_Err && (par_cnt_q != 8'hFF)) par_cnt_d = par_cnt_q + 8'd1;
      if (Framing_Err && (frm_cnt_q != 8'hFF)) frm_cnt_d = frm_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      par_cnt_q <= par_cnt_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign Par_Err_Cnt = par_cnt_q;
  assign Frm_Err_Cnt = frm_cnt_q;
`else
  assign Par_Err_Cnt = '0;
  assign Frm_Err_Cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: scoreboard on the FIFO path, cycle checks on config apply.
module tb_uart_rx_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_ERR_STAT_EN
  localparam int STAT_EN = 1;
`else
  localparam int STAT_EN = 0;
`endif

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Cfg_Wr;
  logic [5:0]       Cfg_Prescale;
  logic             Cfg_Par_En;
  logic             Cfg_Par_Typ;
  logic             Cfg_Busy;
  logic             Rx_in;
  logic [5:0]       Prescale;
  logic             Parity_En;
  logic             Parity_Typ;
  logic [WIDTH-1:0] P_Data;
  logic             Data_Valid;
  logic             Parity_Err;
  logic             Framing_Err;
  logic [WIDTH-1:0] Out_Data;
  logic             Out_Valid;
  logic             Out_Ready;
  logic             Overrun;
  logic [7:0]       Par_Err_Cnt;
  logic [7:0]       Frm_Err_Cnt;
  logic             Clr_Stat;

  uart_rx_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .Cfg_Wr(Cfg_Wr), .Cfg_Prescale(Cfg_Prescale), .Cfg_Par_En(Cfg_Par_En),
    .Cfg_Par_Typ(Cfg_Par_Typ), .Cfg_Busy(Cfg_Busy),
    .Rx_in(Rx_in), .Prescale(Prescale), .Parity_En(Parity_En), .Parity_Typ(Parity_Typ),
    .P_Data(P_Data), .Data_Valid(Data_Valid), .Parity_Err(Parity_Err), .Framing_Err(Framing_Err),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Overrun(Overrun), .Par_Err_Cnt(Par_Err_Cnt), .Frm_Err_Cnt(Frm_Err_Cnt), .Clr_Stat(Clr_Stat)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] p, input logic en, input logic typ);
    Cfg_Wr = 1'b1; Cfg_Prescale = p; Cfg_Par_En = en; Cfg_Par_Typ = typ;
    tick();
    Cfg_Wr = 1'b0;
  endtask

  // Push with Out_Ready low; model decides accept or overrun.
  task automatic push_word(input logic [WIDTH-1:0] d);
    Data_Valid = 1'b1; P_Data = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovr = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    Out_Ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (exp_q.size() == 0) break;
      check({tag, "_valid"}, 32'(Out_Valid), 32'd1);
      check({tag, "_data"}, 32'(Out_Data), 32'(exp_q[0]));
      tick();
      void'(exp_q.pop_front());
    end
    Out_Ready = 1'b0;
    check({tag, "_empty"}, 32'(Out_Valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Rst = 1'b0; Cfg_Wr = 1'b0; Cfg_Prescale = '0; Cfg_Par_En = 1'b0; Cfg_Par_Typ = 1'b0;
    Rx_in = 1'b1; P_Data = '0; Data_Valid = 1'b0; Parity_Err = 1'b0; Framing_Err = 1'b0;
    Out_Ready = 1'b0; Clr_Stat = 1'b0;
    repeat (3) tick();
    Rst = 1'b1;
    tick();
    check("rst_prescale", 32'(Prescale), 32'd8);
    check("rst_par_en", 32'(Parity_En), 32'd0);
    check("rst_par_typ", 32'(Parity_Typ), 32'd0);
    check("rst_cfg_busy", 32'(Cfg_Busy), 32'd0);
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_out_data", 32'(Out_Data), 32'd0);
    check("rst_overrun", 32'(Overrun), 32'd0);
    check("rst_par_cnt", 32'(Par_Err_Cnt), 32'd0);
    check("rst_frm_cnt", 32'(Frm_Err_Cnt), 32'd0);

    // Config write while idle: busy after N, applied after N+1.
    cfg_write(6'd12, 1'b1, 1'b1);
    check("idle_cfg_busy", 32'(Cfg_Busy), 32'd1);
    check("idle_cfg_old", 32'(Prescale), 32'd8);
    tick();
    check("idle_cfg_presc", 32'(Prescale), 32'd12);
    check("idle_cfg_en", 32'(Parity_En), 32'd1);
    check("idle_cfg_typ", 32'(Parity_Typ), 32'd1);
    check("idle_cfg_done", 32'(Cfg_Busy), 32'd0);

    // Mid-frame write is held until the frame ends and the line returns high.
    Rx_in = 1'b0;
    tick();
    cfg_write(6'd16, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("mid_hold_presc", 32'(Prescale), 32'd12);
      check("mid_hold_busy", 32'(Cfg_Busy), 32'd1);
      tick();
    end
    push_word(8'hA5);
    tick(); tick();
    check("wait_high_presc", 32'(Prescale), 32'd12);
    Rx_in = 1'b1;
    tick();
    check("line_high_presc", 32'(Prescale), 32'd12);
    tick();
    check("apply_presc", 32'(Prescale), 32'd12);
    check("apply_busy", 32'(Cfg_Busy), 32'd1);
    tick();
    check("applied_presc", 32'(Prescale), 32'd16);
    check("applied_en", 32'(Parity_En), 32'd0);
    check("applied_busy", 32'(Cfg_Busy), 32'd0);
    drain("drain_a5");

    // Overflow: fifth word dropped.
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    check("full_no_ovr", 32'(Overrun), 32'(exp_ovr));
    push_word(8'h55);
    check("ovr_head", 32'(Out_Data), 32'h11);
    check("ovr_flag", 32'(Overrun), 32'(exp_ovr));
    drain("drain_ovr");
    check("ovr_sticky", 32'(Overrun), 32'd1);
    Clr_Stat = 1'b1; exp_ovr = 1'b0;
    tick();
    Clr_Stat = 1'b0;
    check("ovr_clear", 32'(Overrun), 32'(exp_ovr));

    // Full FIFO with simultaneous push and pop.
    push_word(8'h66); push_word(8'h77); push_word(8'h88); push_word(8'h99);
    Data_Valid = 1'b1; P_Data = 8'hAA; Out_Ready = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(8'hAA);
    tick();
    Data_Valid = 1'b0; Out_Ready = 1'b0;
    check("pp_no_ovr", 32'(Overrun), 32'd0);
    check("pp_head", 32'(Out_Data), 32'h77);
    drain("drain_pp");

    // Error counters.
    Parity_Err = 1'b1;
    repeat (10) tick();
    check("par_cnt_10", 32'(Par_Err_Cnt), 32'(10 * STAT_EN));
    repeat (290) tick();
    Parity_Err = 1'b0;
    check("par_cnt_sat", 32'(Par_Err_Cnt), 32'(255 * STAT_EN));
    Framing_Err = 1'b1;
    repeat (3) tick();
    check("frm_cnt_3", 32'(Frm_Err_Cnt), 32'(3 * STAT_EN));
    Clr_Stat = 1'b1;
    tick();
    Clr_Stat = 1'b0; Framing_Err = 1'b0;
    check("clr_frm_prio", 32'(Frm_Err_Cnt), 32'd0);
    check("clr_par", 32'(Par_Err_Cnt), 32'd0);

    // Timeout with line returning high and no receiver pulses.
    cfg_write(6'd2, 1'b0, 1'b0);
    tick();
    check("presc_2", 32'(Prescale), 32'd2);
    Rx_in = 1'b0;
    tick();
    Rx_in = 1'b1;
    cfg_write(6'd5, 1'b0, 1'b0);
    n = 1;
    while (Prescale != 6'd5 && n < 200) begin
      tick();
      n++;
    end
    // BUSY for T0+1 cycles, then WAIT_HIGH, IDLE, APPLY.
    check("timeout_apply_cycle", 32'(n), 32'(11 * 2 + 4));

    // Line held low past the timeout: held in WAIT_HIGH until it rises.
    Rx_in = 1'b0;
    tick();
    cfg_write(6'd3, 1'b1, 1'b0);
    repeat (70) tick();
    check("low_hold_presc", 32'(Prescale), 32'd5);
    check("low_hold_busy", 32'(Cfg_Busy), 32'd1);
    Rx_in = 1'b1;
    n = 0;
    while (Prescale != 6'd3 && n < 50) begin
      tick();
      n++;
    end
    check("low_release_cycle", 32'(n), 32'd3);
    check("low_release_en", 32'(Parity_En), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
